gated_pipe: RTL and testbench
=============================

Name: gated_pipe

Overview:
- Parametrised successor to the fixed-depth enable/reset-gated register chain.
- A DEPTH-stage, WIDTH-bit valid/ready pipeline in which every stage register loads only when its gating condition is true.
- Adds a global freeze enable, a synchronous clear, an inverted-gating alternate capture register, and a saturating hold-activity counter.
- Sits between a data producer and consumer; used as the standard gated-register regression block for clock-gater inference.

Parameters:
WIDTH, 32, data width in bits (>=1)
DEPTH, 4, number of pipeline stages (>=1)
CNT_W, 16, hold counter width (>=2)
XOR_CONST, 32'h12341234, WIDTH-bit constant mixed into alt_data

Ports:
clk  input  1  clock, rising edge
reset_l  input  1  asynchronous active-low reset
clear  input  1  synchronous clear, active high
enable  input  1  global gate; 0 freezes all stages
in_valid  input  1  producer data valid
in_ready  output  1  pipeline accepts in_data this cycle
in_data  input  WIDTH  producer data
out_valid  output  1  last stage holds valid data
out_ready  input  1  consumer accepts out_data
out_data  output  WIDTH  last stage data
alt_data  output  WIDTH  inverted-gating capture register
hold_cnt  output  CNT_W  saturating count of hold cycles

Behaviour:
- Reset (reset_l=0, async): all valid bits 0, all stage data 0, alt_data 0, hold_cnt 0. Hence out_valid=0, out_data=0, in_ready=0 while reset is asserted.
- Stage i (0..DEPTH-1) holds valid[i] and data[i]; stage DEPTH-1 drives out_valid/out_data directly (registered, no combinational path from in_data).
- Readiness: rdy[DEPTH] = out_ready; rdy[i] = !valid[i] || rdy[i+1]. rdy is combinational, so a full pipe with out_ready=1 streams one word per cycle.
- in_ready = enable && !clear && rdy[0].
- Load condition: ld[i] = enable && !clear && rdy[i].
  - On ld[i], valid[i] <= (i==0 ? in_valid : valid[i-1]).
  - data[i] <= upstream data only when ld[i] and the upstream valid is 1. Data is never written with an invalid word; data stays frozen otherwise (the gating condition).
- Latency: a word accepted at edge N appears with out_valid=1 after edge N+DEPTH-1 when there is no stall, i.e. DEPTH-cycle latency counting the accepting edge.
- Ordering: no drops, duplicates or reordering under any out_ready/enable pattern.
- enable=0 (and clear=0):
  - No stage loads; in_ready=0; valid and data unchanged.
  - alt_data <= ~data[DEPTH-1] ^ XOR_CONST every such cycle, regardless of valid.
  - alt_data holds when enable=1.
- Hold counter: hold event = enable=1, clear=0, out_valid=1, out_ready=0 (stall). hold_cnt increments by 1 per hold event and saturates at 2^CNT_W-1. Frozen cycles (enable=0) do not count.
- clear=1: on that edge all valid bits go to 0, all data to 0, alt_data to 0 and hold_cnt to 0.
  - clear has priority over enable, loads, alt capture and counting.
  - The word presented on in_data is not accepted (in_ready=0).
- Simultaneous in_valid with full stalled pipe: in_ready=0, no accept, nothing changes.
- Reset assertion mid-stream discards all contents immediately (async). The first load is possible on the first edge after reset_l rises.
- DEPTH=1: single register; rdy[0] = !valid[0] || out_ready.

Test Plan:
- Streaming: DEPTH=4, out_ready=1, enable=1, inputs 1,2,3… every cycle from edge 0 -> out_valid rises after edge 3 with out_data=1, then 2,3… every cycle; in_ready stays 1.
- Backpressure: fill with 0xA0..0xA3, out_ready=0 for 5 cycles -> in_ready=0 once full, out_data stays 0xA0, hold_cnt=5; release -> 0xA0..0xA3 emerge in order, no loss.
- Freeze: mid-stream enable=0 for 3 cycles with last stage 0x0000FFFF -> pipe frozen, in_ready=0, alt_data=0xEDCB1234 (~0x0000FFFF ^ 0x12341234), hold_cnt unchanged; resume -> stream continues intact.
- Clear priority: clear=1 with enable=1, in_valid=1, pipe partly full, hold_cnt=7 -> next cycle all valid=0, out_data=0, alt_data=0, hold_cnt=0, input word not accepted.
- Saturation: CNT_W=2, stall 6 cycles -> hold_cnt reads 1,2,3,3,3,3.
- Async reset: drop reset_l between edges mid-stream -> out_valid=0, out_data=0, hold_cnt=0 immediately; after release, a fresh word 0x55 exits DEPTH cycles later.

Source files
------------

// File: rtl/gated_pipe.sv
// gated_pipe: DEPTH-stage valid/ready pipeline whose registers load only under their gate,
// with global freeze, synchronous clear, inverted-gating alt capture and saturating stall counter.
module gated_pipe #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16,
  parameter logic [WIDTH-1:0] XOR_CONST = WIDTH'(32'h12341234)
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             clear,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [WIDTH-1:0] alt_data,
  output logic [CNT_W-1:0] hold_cnt
);
  logic [DEPTH-1:0] valid_q, valid_d, up_v;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [WIDTH-1:0] up_d [DEPTH];
  logic [DEPTH:0]   rdy;
  logic [WIDTH-1:0] alt_q, alt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             go, hold;

  assign up_v[0] = in_valid;
  assign up_d[0] = in_data;
  for (genvar s = 1; s < DEPTH; s++) begin : g_up
    assign up_v[s] = valid_q[s-1];
    assign up_d[s] = data_q[s-1];
  end

  always_comb begin
    rdy[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) rdy[i] = !valid_q[i] || rdy[i+1];
  end

  assign go        = enable && !clear;
  assign hold      = go && valid_q[DEPTH-1] && !out_ready;
  assign in_ready  = reset_l && go && rdy[0];
  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign alt_data  = alt_q;
  assign hold_cnt  = cnt_q;

  // data only ever captures a valid upstream word; an invalid load just drops the valid bit
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (clear) begin
        valid_d[i] = 1'b0;
        data_d[i]  = '0;
      end else if (enable && rdy[i]) begin
        valid_d[i] = up_v[i];
        if (up_v[i]) data_d[i] = up_d[i];
      end
    end
  end

  assign alt_d = clear ? '0 : !enable ? ~data_q[DEPTH-1] ^ XOR_CONST : alt_q;
  assign cnt_d = clear ? '0 : (hold && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      valid_q <= '0;
      data_q  <= '{default: '0};
      alt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      alt_q   <= alt_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_gated_pipe.sv
// tb_gated_pipe: randomized and directed checks of gated_pipe against a slot-level token model.
module tb_gated_pipe;
  localparam int D = 4;
  localparam logic [31:0] XC = 32'h12341234;

  logic clk = 0, reset_l = 0, clear = 0, enable = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_data = 0;
  logic in_ready, out_valid, in_ready2, out_valid2;
  logic [31:0] out_data, alt_data, out_data2, alt_data2;
  logic [15:0] hold_cnt;
  logic [1:0] hold_cnt2;

  int errors = 0, checks = 0;
  bit mv[D];
  bit [31:0] md[D];
  bit [31:0] malt;
  int mcnt, mcnt2;
  bit exp_rdy;
  logic obs_rdy;
  logic [31:0] out_log[$];
  bit [31:0] acc[$];
  logic [80:0] got_st, want_st;

  always #5 clk = ~clk;

  gated_pipe #(.WIDTH(32), .DEPTH(D), .CNT_W(16), .XOR_CONST(XC)) dut (
    .clk(clk), .reset_l(reset_l), .clear(clear), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .alt_data(alt_data), .hold_cnt(hold_cnt));

  gated_pipe #(.WIDTH(32), .DEPTH(D), .CNT_W(2), .XOR_CONST(XC)) dut2 (
    .clk(clk), .reset_l(reset_l), .clear(clear), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .alt_data(alt_data2), .hold_cnt(hold_cnt2));

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      mv[i] = 0;
      md[i] = 0;
    end
    malt = 0;
    mcnt = 0;
    mcnt2 = 0;
  endtask

  // One clock of stimulus; the model treats each stage as a slot that takes a new token
  // when it is empty or its own token moves on this cycle.
  task automatic step(input logic en, input logic clr, input logic iv, input logic [31:0] id,
                      input logic ordy);
    bit opn[D+1];
    enable = en; clear = clr; in_valid = iv; in_data = id; out_ready = ordy;
    #2;
    opn[D] = ordy;
    for (int i = D - 1; i >= 0; i--) opn[i] = !mv[i] || opn[i+1];
    exp_rdy = en && !clr && opn[0];
    obs_rdy = in_ready;
    if (out_valid === 1'b1 && ordy && en && !clr) out_log.push_back(out_data);
    @(posedge clk);
    if (clr) model_reset();
    else if (!en) malt = ~md[D-1] ^ XC;
    else begin
      if (mv[D-1] && !ordy) begin
        mcnt = (mcnt == 65535) ? mcnt : mcnt + 1;
        mcnt2 = (mcnt2 == 3) ? 3 : mcnt2 + 1;
      end
      if (opn[0] && iv) acc.push_back(id);
      for (int i = D - 1; i >= 0; i--)
        if (opn[i]) begin
          if (i == 0) begin
            mv[0] = iv;
            if (iv) md[0] = id;
          end else begin
            mv[i] = mv[i-1];
            if (mv[i-1]) md[i] = md[i-1];
          end
        end
    end
    #1;
    got_st  = {out_valid, out_data, hold_cnt, alt_data};
    want_st = {mv[D-1], md[D-1], mcnt[15:0], malt};
  endtask

  task automatic test_reset();
    enable = 1; in_valid = 1; in_data = 32'hDEAD; out_ready = 1;
    #2;
    checks++;
    if ({out_valid, out_data, in_ready, alt_data, hold_cnt} !== 81'd0) begin
      errors++;
      $display("FAIL reset_state got v=%b d=%h r=%b alt=%h cnt=%0d want all zero",
               out_valid, out_data, in_ready, alt_data, hold_cnt);
    end
    model_reset();
    @(negedge clk);
    reset_l = 1;
  endtask

  task automatic test_stream();
    out_log.delete();
    for (int k = 0; k < 10; k++) begin
      step(1, 0, 1, k + 1, 1);
      checks++;
      if (obs_rdy !== 1'b1) begin
        errors++;
        $display("FAIL stream in_ready step %0d got %b want 1", k, obs_rdy);
      end
      checks++;
      if (got_st !== want_st) begin
        errors++;
        $display("FAIL stream state step %0d got %h want %h", k, got_st, want_st);
      end
      if (k == 3) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'd1) begin
          errors++;
          $display("FAIL stream first_word got v=%b d=%h want v=1 d=1", out_valid, out_data);
        end
      end
    end
    for (int k = 0; k < 4; k++) step(1, 0, 0, 0, 1);
    checks++;
    if (out_log.size() != 10) begin
      errors++;
      $display("FAIL stream count got %0d want 10", out_log.size());
    end else
      for (int k = 0; k < 10; k++) begin
        checks++;
        if (out_log[k] !== k + 1) begin
          errors++;
          $display("FAIL stream order idx %0d got %h want %h", k, out_log[k], k + 1);
        end
      end
  endtask

  task automatic test_backpressure();
    out_log.delete();
    for (int k = 0; k < 4; k++) step(1, 0, 1, 32'hA0 + k, 0);
    for (int k = 0; k < 5; k++) begin
      step(1, 0, 1, 32'hBB, 0);
      checks++;
      if (obs_rdy !== 1'b0 || out_data !== 32'hA0) begin
        errors++;
        $display("FAIL bp stall %0d got in_ready=%b d=%h want 0/a0", k, obs_rdy, out_data);
      end
    end
    checks++;
    if (hold_cnt !== 16'd5 || got_st !== want_st) begin
      errors++;
      $display("FAIL bp hold got cnt=%0d st=%h want cnt=5 st=%h", hold_cnt, got_st, want_st);
    end
    for (int k = 0; k < 4; k++) step(1, 0, 0, 0, 1);
    checks++;
    if (out_log.size() != 4) begin
      errors++;
      $display("FAIL bp count got %0d want 4", out_log.size());
    end else
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (out_log[k] !== 32'hA0 + k) begin
          errors++;
          $display("FAIL bp order idx %0d got %h want %h", k, out_log[k], 32'hA0 + k);
        end
      end
  endtask

  task automatic test_freeze();
    logic [31:0] exp_seq[6];
    exp_seq = '{32'hFFFF, 2, 3, 4, 5, 6};
    out_log.delete();
    step(1, 0, 1, 32'h0000FFFF, 1);
    for (int k = 2; k <= 4; k++) step(1, 0, 1, k, 1);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 1, 32'h99, 1);
      checks++;
      if (obs_rdy !== 1'b0 || alt_data !== 32'hEDCB1234 || hold_cnt !== 16'd5 ||
          out_data !== 32'h0000FFFF || got_st !== want_st) begin
        errors++;
        $display("FAIL freeze %0d got r=%b alt=%h cnt=%0d d=%h want r=0 alt=edcb1234 cnt=5 d=0000ffff",
                 k, obs_rdy, alt_data, hold_cnt, out_data);
      end
    end
    step(1, 0, 1, 5, 1);
    step(1, 0, 1, 6, 1);
    for (int k = 0; k < 4; k++) step(1, 0, 0, 0, 1);
    checks++;
    if (out_log.size() != 6 || alt_data !== 32'hEDCB1234) begin
      errors++;
      $display("FAIL freeze resume got n=%0d alt=%h want n=6 alt=edcb1234", out_log.size(), alt_data);
    end else
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (out_log[k] !== exp_seq[k]) begin
          errors++;
          $display("FAIL freeze order idx %0d got %h want %h", k, out_log[k], exp_seq[k]);
        end
      end
  endtask

  task automatic test_clear();
    step(1, 0, 1, 32'h31, 0);
    step(1, 0, 1, 32'h32, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    checks++;
    if (hold_cnt !== 16'd7 || got_st !== want_st) begin
      errors++;
      $display("FAIL clear setup got cnt=%0d st=%h want cnt=7 st=%h", hold_cnt, got_st, want_st);
    end
    step(1, 1, 1, 32'h77, 1);
    checks++;
    if (obs_rdy !== 1'b0 || {out_valid, out_data, alt_data, hold_cnt} !== 81'd0) begin
      errors++;
      $display("FAIL clear prio got r=%b v=%b d=%h alt=%h cnt=%0d want all zero",
               obs_rdy, out_valid, out_data, alt_data, hold_cnt);
    end
    out_log.delete();
    for (int k = 0; k < 4; k++) step(1, 0, 0, 0, 1);
    checks++;
    if (out_log.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear no_accept got n=%0d v=%b want n=0 v=0", out_log.size(), out_valid);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt[6];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    step(1, 0, 1, 32'h44, 0);
    for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      step(1, 0, 0, 0, 0);
      checks++;
      if (hold_cnt2 !== exp_cnt[k] || hold_cnt2 !== 2'(mcnt2)) begin
        errors++;
        $display("FAIL sat stall %0d got %0d want %0d", k, hold_cnt2, exp_cnt[k]);
      end
    end
    step(1, 0, 0, 0, 1);
  endtask

  task automatic test_random();
    logic en, iv, ordy;
    out_log.delete();
    acc.delete();
    for (int k = 0; k < 300; k++) begin
      en = ($urandom % 6) != 0;
      iv = $urandom % 2;
      ordy = ($urandom % 3) != 0;
      step(en, 0, iv, $urandom, ordy);
      checks++;
      if (obs_rdy !== exp_rdy || got_st !== want_st) begin
        errors++;
        $display("FAIL random step %0d got r=%b st=%h want r=%b st=%h", k, obs_rdy, got_st, exp_rdy, want_st);
      end
    end
    for (int k = 0; k < 8; k++) step(1, 0, 0, 0, 1);
    checks++;
    if (out_log.size() != acc.size()) begin
      errors++;
      $display("FAIL random count got %0d want %0d", out_log.size(), acc.size());
    end else
      for (int k = 0; k < acc.size(); k++) begin
        checks++;
        if (out_log[k] !== acc[k]) begin
          errors++;
          $display("FAIL random order idx %0d got %h want %h", k, out_log[k], acc[k]);
        end
      end
  endtask

  task automatic test_async_reset();
    step(1, 0, 1, 32'h61, 0);
    step(1, 0, 1, 32'h62, 0);
    for (int k = 0; k < 4; k++) step(1, 0, 0, 0, 0);
    #2;
    reset_l = 0;
    #1;
    checks++;
    if ({out_valid, out_data, hold_cnt, in_ready} !== 50'd0) begin
      errors++;
      $display("FAIL areset got v=%b d=%h cnt=%0d r=%b want all zero", out_valid, out_data, hold_cnt, in_ready);
    end
    model_reset();
    @(negedge clk);
    reset_l = 1;
    step(1, 0, 1, 32'h55, 1);
    checks++;
    if (obs_rdy !== 1'b1) begin
      errors++;
      $display("FAIL areset first_load got in_ready=%b want 1", obs_rdy);
    end
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 0, 1);
      checks++;
      if (got_st !== want_st || out_valid !== (k == 2) || (k == 2 && out_data !== 32'h55)) begin
        errors++;
        $display("FAIL areset latency %0d got v=%b d=%h want v=%b d=55", k, out_valid, out_data, k == 2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_freeze();
    test_clear();
    test_saturation();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
